// File: rtl/ser_pkg.sv
// Shared definitions for the 64-to-32 word serializer: FSM state encoding and default beat width.
package ser_pkg;

    localparam int SER_BEAT_W = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT0 = 2'd1;
    localparam logic [1:0] ST_BEAT1 = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        BEAT0 = ST_BEAT0,
        BEAT1 = ST_BEAT1
    } ser_state_t;

endpackage

// File: rtl/ser_word_reg.sv
// Load-enable holding register for the captured word, cleared asynchronously by clr_n.
module ser_word_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/word_serializer_64.sv
// Splits each accepted 2*BEAT_W word into two BEAT_W beats with valid/ready on both sides.
// Optional build macro SER_HI_FIRST_EN sends the high half first; out_last still marks the second beat.
module word_serializer_64
    import ser_pkg::*;
#(
    parameter int BEAT_W = SER_BEAT_W,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic [2*BEAT_W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [BEAT_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic [CNT_W-1:0]    words_sent,
    output ser_state_t          dbg_state
);

    // Handshake: a beat or word moves only on a rising edge where valid && ready;
    // the offering side keeps data/valid (and last) stable until that edge.

    ser_state_t          state_q;
    ser_state_t          state_d;
    logic [2*BEAT_W-1:0] word_q;
    logic [BEAT_W-1:0]   first_beat;
    logic [BEAT_W-1:0]   second_beat;
    logic                in_take;
    logic                out_take;
    logic [CNT_W-1:0]    words_sent_q;

`ifdef SER_HI_FIRST_EN
    assign first_beat  = word_q[2*BEAT_W-1:BEAT_W];
    assign second_beat = word_q[BEAT_W-1:0];
`else
    assign first_beat  = word_q[BEAT_W-1:0];
    assign second_beat = word_q[2*BEAT_W-1:BEAT_W];
`endif

    // BEAT1 passes out_ready straight through so a new word can follow with no bubble.
    assign in_ready  = clr_n && ((state_q == IDLE) || ((state_q == BEAT1) && out_ready));
    assign in_take   = in_valid && in_ready;
    assign out_valid = (state_q != IDLE);
    assign out_last  = (state_q == BEAT1);
    assign out_take  = out_valid && out_ready;

    ser_word_reg #(
        .W(2*BEAT_W)
    ) u_word_reg (
        .clk  (clk),
        .clr_n(clr_n),
        .load (in_take),
        .d    (in_data),
        .q    (word_q)
    );

    always_comb begin
        out_data = '0;
        case (state_q)
            BEAT0:   out_data = first_beat;
            BEAT1:   out_data = second_beat;
            default: out_data = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = BEAT0;
            BEAT0:   if (out_ready) state_d = BEAT1;
            BEAT1:   if (out_ready) state_d = in_valid ? BEAT0 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            words_sent_q <= '0;
        end else if (out_take && out_last) begin
            words_sent_q <= words_sent_q + CNT_W'(1);
        end
    end

    assign words_sent = words_sent_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_word_serializer_64.sv
// Directed bench for word_serializer_64; honours SER_HI_FIRST_EN when picking expected beat order.
module tb_word_serializer_64;
    import ser_pkg::*;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, out_last;
    logic [31:0] out_data;
    logic [15:0] words_sent;
    ser_state_t  dbg_state;

    logic        d4_in_ready, d4_out_valid, d4_out_last;
    logic [31:0] d4_out_data;
    logic [3:0]  d4_words_sent;
    ser_state_t  d4_dbg_state;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    word_serializer_64 #(.BEAT_W(32), .CNT_W(16)) u_dut (
        .clk(clk), .clr_n(clr_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .words_sent(words_sent), .dbg_state(dbg_state)
    );

    word_serializer_64 #(.BEAT_W(32), .CNT_W(4)) u_dut4 (
        .clk(clk), .clr_n(clr_n), .in_data(in_data), .in_valid(in_valid), .in_ready(d4_in_ready),
        .out_data(d4_out_data), .out_valid(d4_out_valid), .out_ready(out_ready), .out_last(d4_out_last),
        .words_sent(d4_words_sent), .dbg_state(d4_dbg_state)
    );

    typedef struct {
        logic [63:0] in_data;
        logic        in_valid;
        logic        out_ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_last;
        logic        exp_in_ready;
    } vec_t;

    function automatic logic [31:0] first_of(input logic [63:0] w);
`ifdef SER_HI_FIRST_EN
        return w[63:32];
`else
        return w[31:0];
`endif
    endfunction

    function automatic logic [31:0] second_of(input logic [63:0] w);
`ifdef SER_HI_FIRST_EN
        return w[31:0];
`else
        return w[63:32];
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        in_data   = v.in_data;
        in_valid  = v.in_valid;
        out_ready = v.out_ready;
        @(negedge clk);
        chk($sformatf("vec%0d out_valid", idx), 64'(out_valid), 64'(v.exp_valid));
        chk($sformatf("vec%0d out_data", idx), 64'(out_data), 64'(v.exp_data));
        chk($sformatf("vec%0d out_last", idx), 64'(out_last), 64'(v.exp_last));
        chk($sformatf("vec%0d in_ready", idx), 64'(in_ready), 64'(v.exp_in_ready));
        next_cycle();
    endtask

    localparam logic [63:0] W1 = 64'h1122_3344_5566_7788;
    localparam logic [63:0] WA = 64'hA0A1_A2A3_A4A5_A6A7;
    localparam logic [63:0] WB = 64'hB0B1_B2B3_B4B5_B6B7;
    localparam logic [63:0] WC = 64'hC0C1_C2C3_C4C5_C6C7;
    localparam logic [63:0] WD = 64'hD0D1_D2D3_D4D5_D6D7;

    initial begin
        vec_t tbl[10];
        logic [63:0] words[17];
        int next_idx, cycles, beats;
        logic exp_last_bit;
        logic [31:0] exp_beat;

        tbl[0] = '{W1,    1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1};
        tbl[1] = '{64'h0, 1'b0, 1'b1, 1'b1, first_of(W1),  1'b0, 1'b0};
        tbl[2] = '{64'h0, 1'b0, 1'b1, 1'b1, second_of(W1), 1'b1, 1'b1};
        tbl[3] = '{64'h0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1};
        tbl[4] = '{WA,    1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1};
        tbl[5] = '{WB,    1'b1, 1'b1, 1'b1, first_of(WA),  1'b0, 1'b0};
        tbl[6] = '{WB,    1'b1, 1'b1, 1'b1, second_of(WA), 1'b1, 1'b1};
        tbl[7] = '{64'h0, 1'b0, 1'b1, 1'b1, first_of(WB),  1'b0, 1'b0};
        tbl[8] = '{64'h0, 1'b0, 1'b1, 1'b1, second_of(WB), 1'b1, 1'b1};
        tbl[9] = '{64'h0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1};
        for (int k = 0; k < 17; k++) words[k] = {32'h5000_0000 + 32'(k), 32'hA000_0000 + 32'(k)};

        // Reset values while clr_n is held low.
        #2;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_last", 64'(out_last), 64'd0);
        chk("rst out_data", 64'(out_data), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst words_sent", 64'(words_sent), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;

        // Single word, then back-to-back A,B with in_valid held high.
        for (int i = 0; i < 10; i++) begin
            apply_vec(tbl[i], i);
            if (i == 3) chk("t1 words_sent", 64'(words_sent), 64'd1);
        end
        chk("t2 words_sent", 64'(words_sent), 64'd3);

        // Back-pressure in BEAT0 with changing input data.
        in_data = WC; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("t3 accept in_ready", 64'(in_ready), 64'd1);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = {$urandom(), $urandom()};
            @(negedge clk);
            chk("t3 hold out_valid", 64'(out_valid), 64'd1);
            chk("t3 hold out_data", 64'(out_data), 64'(first_of(WC)));
            chk("t3 hold out_last", 64'(out_last), 64'd0);
            chk("t3 hold in_ready", 64'(in_ready), 64'd0);
            next_cycle();
        end
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("t3 beat0 data", 64'(out_data), 64'(first_of(WC)));
        next_cycle();
        @(negedge clk);
        chk("t3 beat1 data", 64'(out_data), 64'(second_of(WC)));
        chk("t3 beat1 last", 64'(out_last), 64'd1);
        next_cycle();
        chk("t3 words_sent", 64'(words_sent), 64'd4);

        // Asynchronous reset pulse while BEAT1 is stalled.
        in_data = WD; in_valid = 1'b1; out_ready = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        out_ready = 1'b0;
        #1;
        chk("t4 pre last", 64'(out_last), 64'd1);
        chk("t4 pre data", 64'(out_data), 64'(second_of(WD)));
        clr_n = 1'b0;
        #1;
        chk("t4 rst out_valid", 64'(out_valid), 64'd0);
        chk("t4 rst out_last", 64'(out_last), 64'd0);
        chk("t4 rst out_data", 64'(out_data), 64'd0);
        chk("t4 rst in_ready", 64'(in_ready), 64'd0);
        chk("t4 rst words_sent", 64'(words_sent), 64'd0);
        chk("t4 rst words_sent4", 64'(d4_words_sent), 64'd0);
        #1;
        clr_n = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("t4 idle out_valid", 64'(out_valid), 64'd0);
        chk("t4 idle in_ready", 64'(in_ready), 64'd1);
        next_cycle();

        // 17 back-to-back words through both counter widths, beats checked in order.
        out_ready = 1'b1;
        next_idx = 0; cycles = 0; beats = 0; exp_last_bit = 1'b0;
        while ((next_idx < 17 || exp_q.size() > 0) && cycles < 100) begin
            in_valid = (next_idx < 17);
            in_data  = in_valid ? words[next_idx] : 64'h0;
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(first_of(words[next_idx]));
                exp_q.push_back(second_of(words[next_idx]));
                next_idx++;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("t5 unexpected beat", 64'(out_data), 64'hDEAD);
                end else begin
                    exp_beat = exp_q.pop_front();
                    chk("t5 beat data", 64'(out_data), 64'(exp_beat));
                    chk("t5 beat last", 64'(out_last), 64'(exp_last_bit));
                    exp_last_bit = ~exp_last_bit;
                    beats++;
                end
            end
            next_cycle();
            cycles++;
        end
        chk("t5 timeout", 64'(cycles < 100), 64'd1);
        chk("t5 beats", 64'(beats), 64'd34);
        chk("t5 no-bubble cycles", 64'(cycles), 64'd35);
        chk("t5 words_sent16", 64'(words_sent), 64'd17);
        chk("t5 words_sent4 wrap", 64'(d4_words_sent), 64'd1);
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
